// File: rtl/text_row_scheduler.sv
// text_row_scheduler
//   Holds one row of up to SLOTS glyph codes in a double buffer. A writer fills
//   the shadow buffer. A commit arms a swap, and the swap copies shadow into
//   active at the next frame boundary (hcount==0 && vcount==0). While the
//   raster crosses the row, the block tells the sprite renderer which letter
//   to draw, and where.
//
// Ports
//   pixel_clk_in        sole clock, rising edge
//   rst_in              synchronous active-high reset
//   hcount_in/vcount_in raster position (output reflects it one cycle later)
//   base_x_in/base_y_in requested row origin, latched at each frame boundary
//   wr_valid_in/wr_letter_in/wr_ready_out  letter write handshake
//   clear_in            empty the shadow buffer
//   commit_in           arm a shadow->active swap for the next frame boundary
//   commit_pending_out  a swap is armed and not yet performed
//   count_out           letters held in the shadow buffer
//   letter_out/x_out/y_out  registered glyph code and cell origin
//
// Handshake: a write transfers on a rising edge where wr_valid_in and
// wr_ready_out are both high. wr_ready_out is combinational and does not
// depend on wr_valid_in. The writer may hold wr_valid_in and wr_letter_in
// across cycles; each cycle with ready high consumes one letter.
module text_row_scheduler #(
  parameter int SLOTS   = 16,
  parameter int GLYPH_W = 38,
  parameter int GLYPH_H = 45
) (
  input  logic                     pixel_clk_in,
  input  logic                     rst_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic [10:0]              base_x_in,
  input  logic [9:0]               base_y_in,
  input  logic                     wr_valid_in,
  input  logic [4:0]               wr_letter_in,
  output logic                     wr_ready_out,
  input  logic                     clear_in,
  input  logic                     commit_in,
  output logic                     commit_pending_out,
  output logic [$clog2(SLOTS):0]   count_out,
  output logic [4:0]               letter_out,
  output logic [10:0]              x_out,
  output logic [9:0]               y_out
);

  localparam int IW  = $clog2(SLOTS);
  localparam int CW  = IW + 1;
  localparam int CLW = $clog2(GLYPH_W + 1);
  localparam logic [10:0]    GW11    = 11'(GLYPH_W);
  localparam logic [10:0]    ROW_W11 = 11'(GLYPH_W * SLOTS);
  localparam logic [9:0]     GH10    = 10'(GLYPH_H);
  localparam logic [CLW-1:0] COL_MAX = CLW'(GLYPH_W - 1);

  logic [4:0]     shadow_mem [SLOTS];
  logic [4:0]     active_mem [SLOTS];
  logic [CW-1:0]  shadow_count;
  logic [CW-1:0]  active_count;
  logic           commit_pending;
  logic [10:0]    bx;
  logic [9:0]     by;

  // Column tracker state for the previous pixel: slot index, column in cell, cell left edge.
  logic [CW-1:0]  slot_r, slot_c;
  logic [CLW-1:0] col_r, col_c;
  logic [10:0]    cell_x_r, cell_x_c;

  logic           frame_bnd;
  logic [10:0]    h_off;
  logic [9:0]     v_off;
  logic           row_hit;
  logic [4:0]     letter_c;

  assign frame_bnd          = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign wr_ready_out       = (shadow_count < CW'(SLOTS)) && !commit_pending && !clear_in && !rst_in;
  assign commit_pending_out = commit_pending;
  assign count_out          = shadow_count;

  // Modular offsets so a row origin near the edge wraps instead of saturating.
  assign h_off   = hcount_in - bx;
  assign v_off   = vcount_in - by;
  assign row_hit = (v_off < GH10) && (h_off < ROW_W11);

  // Slot index without a divider. The counter restarts at the row's left edge.
  // It relies on hcount advancing by one per cycle across the row.
  always_comb begin
    slot_c   = slot_r;
    col_c    = col_r;
    cell_x_c = cell_x_r;
    if (hcount_in == bx) begin
      slot_c   = '0;
      col_c    = '0;
      cell_x_c = bx;
    end else if (col_r == COL_MAX) begin
      slot_c   = slot_r + CW'(1);
      col_c    = '0;
      cell_x_c = cell_x_r + GW11;
    end else begin
      col_c = col_r + CLW'(1);
    end
  end

  always_comb begin
    letter_c = 5'd0;
    if (slot_c < active_count) letter_c = active_mem[slot_c[IW-1:0]];
  end

  // Buffer storage carries no reset. The counts alone define what is valid.
  always_ff @(posedge pixel_clk_in) begin
    if (wr_valid_in && wr_ready_out)
      shadow_mem[shadow_count[IW-1:0]] <= wr_letter_in;
    if (!rst_in && frame_bnd && commit_pending)
      for (int i = 0; i < SLOTS; i++) active_mem[i] <= shadow_mem[i];
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      shadow_count   <= '0;
      active_count   <= '0;
      commit_pending <= 1'b0;
      bx             <= '0;
      by             <= '0;
      slot_r         <= '0;
      col_r          <= '0;
      cell_x_r       <= '0;
      letter_out     <= '0;
      x_out          <= '0;
      y_out          <= '0;
    end else begin
      slot_r   <= slot_c;
      col_r    <= col_c;
      cell_x_r <= cell_x_c;

      if (clear_in)
        shadow_count <= '0;
      else if (wr_valid_in && wr_ready_out)
        shadow_count <= shadow_count + CW'(1);

      if (frame_bnd) begin
        bx <= base_x_in;
        by <= base_y_in;
      end

      // On a boundary, a pending swap is consumed. Otherwise, a commit arms
      // the swap, and a commit on the boundary cycle itself waits a frame.
      if (frame_bnd && commit_pending) begin
        active_count   <= shadow_count;
        commit_pending <= 1'b0;
      end else if (commit_in) begin
        commit_pending <= 1'b1;
      end

      if (row_hit) begin
        letter_out <= letter_c;
        x_out      <= cell_x_c;
      end else begin
        letter_out <= 5'd0;
        x_out      <= bx;
      end
      y_out <= by;
    end
  end

endmodule

// File: tb/tb_text_row_scheduler.sv
module tb_text_row_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = 11'd500;
  logic [9:0]  vcount = 10'd300;
  logic [10:0] base_x = 11'd0;
  logic [9:0]  base_y = 10'd0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_letter = 5'd0;
  logic        wr_ready;
  logic        clear = 1'b0;
  logic        commit = 1'b0;
  logic        pending;
  logic [4:0]  count;
  logic [4:0]  letter;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;

  int checks = 0;
  int errors = 0;

  logic [4:0]  obs_letter [0:2047];
  logic [10:0] obs_x      [0:2047];
  logic [9:0]  obs_y      [0:2047];

  text_row_scheduler dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst),
    .hcount_in          (hcount),
    .vcount_in          (vcount),
    .base_x_in          (base_x),
    .base_y_in          (base_y),
    .wr_valid_in        (wr_valid),
    .wr_letter_in       (wr_letter),
    .wr_ready_out       (wr_ready),
    .clear_in           (clear),
    .commit_in          (commit),
    .commit_pending_out (pending),
    .count_out          (count),
    .letter_out         (letter),
    .x_out              (x_pos),
    .y_out              (y_pos)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    hcount = 11'd500;
    vcount = 10'd300;
  endtask

  task automatic write_letter(input logic [4:0] l);
    wr_letter = l;
    wr_valid  = 1'b1;
    tick();
    wr_valid  = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic frame_boundary();
    hcount = 11'd0;
    vcount = 10'd0;
    tick();
    park();
  endtask

  // Drives one line segment sequentially. It records the output seen one
  // cycle after each hcount value.
  task automatic sweep(input logic [9:0] v, input int h0, input int h1);
    vcount = v;
    for (int h = h0; h <= h1; h++) begin
      hcount = 11'(h);
      tick();
      obs_letter[h] = letter;
      obs_x[h]      = x_pos;
      obs_y[h]      = y_pos;
    end
    park();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (letter !== 5'd0) begin errors++; $display("FAIL reset_letter got %0d want 0", letter); end
    checks++; if (x_pos !== 11'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x_pos); end
    checks++; if (y_pos !== 10'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y_pos); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b want 0", pending); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %0b want 0", wr_ready); end
    rst = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %0b want 1", wr_ready); end
  endtask

  task automatic test_basic_render();
    base_x = 11'd100;
    base_y = 10'd50;
    write_letter(5'd8);
    write_letter(5'd9);
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL basic_count got %0d want 2", count); end
    do_commit();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL basic_pending got %0b want 1", pending); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_pending got %0b want 0", wr_ready); end
    frame_boundary();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL basic_pending_clr got %0b want 0", pending); end
    sweep(10'd60, 95, 180);
    checks++; if (obs_letter[100] !== 5'd8 || obs_x[100] !== 11'd100 || obs_y[100] !== 10'd50) begin errors++;
      $display("FAIL basic_h100 got l=%0d x=%0d y=%0d want l=8 x=100 y=50", obs_letter[100], obs_x[100], obs_y[100]); end
    checks++; if (obs_letter[138] !== 5'd9 || obs_x[138] !== 11'd138) begin errors++;
      $display("FAIL basic_h138 got l=%0d x=%0d want l=9 x=138", obs_letter[138], obs_x[138]); end
    checks++; if (obs_letter[176] !== 5'd0 || obs_x[176] !== 11'd176) begin errors++;
      $display("FAIL basic_h176 got l=%0d x=%0d want l=0 x=176", obs_letter[176], obs_x[176]); end
    checks++; if (obs_letter[99] !== 5'd0 || obs_x[99] !== 11'd100 || obs_y[99] !== 10'd50) begin errors++;
      $display("FAIL basic_h99 got l=%0d x=%0d y=%0d want l=0 x=100 y=50", obs_letter[99], obs_x[99], obs_y[99]); end
  endtask

  task automatic test_full_buffer();
    do_clear();
    for (int i = 1; i <= 16; i++) write_letter(5'(i));
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", count); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", wr_ready); end
    wr_letter = 5'd26;
    wr_valid  = 1'b1;
    tick();
    tick();
    wr_valid  = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count_hold got %0d want 16", count); end
    do_commit();
    frame_boundary();
    sweep(10'd60, 95, 710);
    checks++; if (obs_letter[100] !== 5'd1) begin errors++; $display("FAIL full_slot0 got %0d want 1", obs_letter[100]); end
    checks++; if (obs_letter[670] !== 5'd16 || obs_x[670] !== 11'd670) begin errors++;
      $display("FAIL full_slot15 got l=%0d x=%0d want l=16 x=670", obs_letter[670], obs_x[670]); end
    checks++; if (obs_letter[708] !== 5'd0 || obs_x[708] !== 11'd100) begin errors++;
      $display("FAIL full_past_row got l=%0d x=%0d want l=0 x=100", obs_letter[708], obs_x[708]); end
  endtask

  task automatic test_clear_vs_write();
    do_clear();
    write_letter(5'd5);
    write_letter(5'd6);
    write_letter(5'd7);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL clr_count3 got %0d want 3", count); end
    clear     = 1'b1;
    wr_valid  = 1'b1;
    wr_letter = 5'd9;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %0b want 0", wr_ready); end
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL clr_count0 got %0d want 0", count); end
    write_letter(5'd10);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL clr_count1 got %0d want 1", count); end
    do_commit();
    frame_boundary();
    sweep(10'd60, 95, 140);
    checks++; if (obs_letter[100] !== 5'd10) begin errors++; $display("FAIL clr_slot0 got %0d want 10", obs_letter[100]); end
    checks++; if (obs_letter[138] !== 5'd0) begin errors++; $display("FAIL clr_slot1 got %0d want 0", obs_letter[138]); end
  endtask

  task automatic test_deferred_commit();
    do_clear();
    write_letter(5'd20);
    write_letter(5'd21);
    do_commit();
    base_x = 11'd200;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL def_pending got %0b want 1", pending); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL def_ready got %0b want 0", wr_ready); end
    sweep(10'd60, 95, 140);
    checks++; if (obs_letter[100] !== 5'd10 || obs_x[100] !== 11'd100 || obs_y[100] !== 10'd50) begin errors++;
      $display("FAIL def_old_h100 got l=%0d x=%0d y=%0d want l=10 x=100 y=50", obs_letter[100], obs_x[100], obs_y[100]); end
    checks++; if (obs_letter[138] !== 5'd0 || obs_x[138] !== 11'd138) begin errors++;
      $display("FAIL def_old_h138 got l=%0d x=%0d want l=0 x=138", obs_letter[138], obs_x[138]); end
    hcount = 11'd1;
    vcount = 10'd0;
    tick();
    park();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL def_not_boundary got %0b want 1", pending); end
    frame_boundary();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL def_pending_fall got %0b want 0", pending); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL def_ready_after got %0b want 1", wr_ready); end
    sweep(10'd60, 195, 240);
    checks++; if (obs_letter[199] !== 5'd0 || obs_x[199] !== 11'd200) begin errors++;
      $display("FAIL def_h199 got l=%0d x=%0d want l=0 x=200", obs_letter[199], obs_x[199]); end
    checks++; if (obs_letter[200] !== 5'd20 || obs_x[200] !== 11'd200) begin errors++;
      $display("FAIL def_h200 got l=%0d x=%0d want l=20 x=200", obs_letter[200], obs_x[200]); end
    checks++; if (obs_letter[238] !== 5'd21 || obs_x[238] !== 11'd238) begin errors++;
      $display("FAIL def_h238 got l=%0d x=%0d want l=21 x=238", obs_letter[238], obs_x[238]); end
  endtask

  task automatic test_commit_at_boundary();
    do_clear();
    write_letter(5'd3);
    hcount = 11'd0;
    vcount = 10'd0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    park();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL cab_pending got %0b want 1", pending); end
    sweep(10'd60, 195, 205);
    checks++; if (obs_letter[200] !== 5'd20) begin errors++; $display("FAIL cab_old got %0d want 20", obs_letter[200]); end
    frame_boundary();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL cab_pending_clr got %0b want 0", pending); end
    sweep(10'd60, 195, 205);
    checks++; if (obs_letter[200] !== 5'd3) begin errors++; $display("FAIL cab_new got %0d want 3", obs_letter[200]); end
  endtask

  task automatic test_reset_mid();
    do_clear();
    write_letter(5'd4);
    do_commit();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rmid_pending_set got %0b want 1", pending); end
    vcount = 10'd60;
    for (int h = 195; h <= 205; h++) begin
      hcount = 11'(h);
      tick();
    end
    checks++; if (letter !== 5'd3) begin errors++; $display("FAIL rmid_hit got %0d want 3", letter); end
    rst = 1'b1;
    tick();
    checks++; if (letter !== 5'd0 || x_pos !== 11'd0 || y_pos !== 10'd0) begin errors++;
      $display("FAIL rmid_outputs got l=%0d x=%0d y=%0d want 0 0 0", letter, x_pos, y_pos); end
    checks++; if (pending !== 1'b0 || count !== 5'd0) begin errors++;
      $display("FAIL rmid_state got pending=%0b count=%0d want 0 0", pending, count); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_low got %0b want 0", wr_ready); end
    rst = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got %0b want 1", wr_ready); end
    park();
    frame_boundary();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rmid_no_swap got %0b want 0", pending); end
    sweep(10'd60, 195, 240);
    checks++; if (obs_letter[200] !== 5'd0 || obs_x[200] !== 11'd200 || obs_y[200] !== 10'd50) begin errors++;
      $display("FAIL rmid_blank_h200 got l=%0d x=%0d y=%0d want l=0 x=200 y=50", obs_letter[200], obs_x[200], obs_y[200]); end
    checks++; if (obs_letter[238] !== 5'd0 || obs_x[238] !== 11'd238) begin errors++;
      $display("FAIL rmid_blank_h238 got l=%0d x=%0d want l=0 x=238", obs_letter[238], obs_x[238]); end
  endtask

  initial begin
    test_reset();
    test_basic_render();
    test_full_buffer();
    test_clear_vs_write();
    test_deferred_commit();
    test_commit_at_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_row_scheduler.md
TEXT_ROW_SCHEDULER -- requirements
Module: text_row_scheduler

Interface
REQ-001 SHALL have parameter SLOTS, default 16: number of glyph cells in the text row (power of two, 2..32).
REQ-002 SHALL have parameter GLYPH_W, default 38, and GLYPH_H, default 45: glyph cell size in pixels.
REQ-003 pixel_clk_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 hcount_in  input  11  current pixel column.
REQ-006 vcount_in  input  10  current pixel row.
REQ-007 base_x_in  input  11  requested left edge of the row; sampled only at frame boundary.
REQ-008 base_y_in  input  10  requested top edge of the row; sampled only at frame boundary.
REQ-009 wr_valid_in  input  1  letter write request.
REQ-010 wr_letter_in  input  5  letter code: 1..26 = A..Z; any other value is stored as-is and renders blank.
REQ-011 wr_ready_out  output  1  shadow buffer accepts a write this cycle.
REQ-012 clear_in  input  1  empty the shadow buffer.
REQ-013 commit_in  input  1  request shadow-to-active swap at the next frame boundary.
REQ-014 commit_pending_out  output  1  a swap is armed and not yet performed.
REQ-015 count_out  output  $clog2(SLOTS)+1  letters held in the shadow buffer.
REQ-016 letter_out  output  5  letter code for the sprite renderer.
REQ-017 x_out  output  11  left edge of the current glyph cell.
REQ-018 y_out  output  10  top edge of the text row.

Function
REQ-019 SHALL hold two buffers of SLOTS x 5 bits: shadow (written) and active (displayed), each with its own count.
REQ-020 SHALL accept a write when wr_valid_in && wr_ready_out: store the letter at shadow[shadow_count], then increment shadow_count.
REQ-021 wr_ready_out SHALL be 1 iff shadow_count < SLOTS && !commit_pending_out && !clear_in && !rst_in.
REQ-022 clear_in SHALL set shadow_count to 0 on the next edge; a simultaneous write SHALL be dropped, because ready is low.
REQ-023 commit_in SHALL set commit_pending_out on the next edge; commit_in while already pending SHALL have no effect.
REQ-024 Frame boundary is defined as the cycle in which hcount_in==0 && vcount_in==0.
REQ-025 At a frame boundary with commit_pending_out=1, the block SHALL, on that edge:
  - copy shadow to active, including the count;
  - clear commit_pending_out;
  - leave shadow contents and shadow_count unchanged.
REQ-026 commit_in asserted in a frame-boundary cycle with nothing pending SHALL arm a swap for the following frame boundary, not the current one.
REQ-027 At every frame boundary the block SHALL latch base_x_in and base_y_in into bx and by, whether or not a commit is pending.
REQ-028 Between boundaries, the active buffer, bx and by SHALL NOT change.
REQ-029 Row hit is defined as vcount_in in [by, by+GLYPH_H) && hcount_in in [bx, bx+GLYPH_W*SLOTS).
REQ-030 On a row hit, slot k = (hcount_in-bx)/GLYPH_W. The block SHALL compute k without a divider, using a per-line column counter that restarts at hcount_in==bx.
REQ-031 Outputs SHALL be registered with a latency of 1 cycle. The values at edge t+1 SHALL reflect hcount_in/vcount_in at edge t; the integrator delays hcount/vcount by 1 cycle toward the renderer.
REQ-032 On a row hit with k < active_count:
  - letter_out = active[k];
  - x_out = bx + GLYPH_W*k;
  - y_out = by.
REQ-033 On a row hit with k >= active_count: letter_out = 0, with x_out and y_out as in REQ-032.
REQ-034 Outside a row hit: letter_out = 0, x_out = bx, y_out = by.
REQ-035 The block SHALL compute all arithmetic at output width; an operand that overflows 11/10 bits SHALL wrap modulo 2^11/2^10 with no saturation.
REQ-036 count_out SHALL equal shadow_count and SHALL saturate at SLOTS.

Reset
REQ-037 While rst_in=1, on each edge the block SHALL drive letter_out=0, x_out=0, y_out=0, count_out=0 and commit_pending_out=0; it SHALL also clear shadow_count, active_count, bx and by to 0.
REQ-038 wr_ready_out SHALL be 0 while rst_in=1 and 1 in the first cycle after deassertion.
REQ-039 Reset asserted mid-line or with a commit pending SHALL discard the pending swap; the active buffer SHALL display nothing until the next commit.

Verification
REQ-040 The bench SHALL cover basic render:
  - stimulus: base (100,50); write 8 then 9; commit; run to the frame boundary;
  - response: with vcount=60, hcount=100 gives letter 8 / x 100; hcount=138 gives letter 9 / x 138; hcount=176 gives letter 0 / x 176; hcount=99 gives letter 0, each one cycle later.
REQ-041 The bench SHALL cover full buffer:
  - stimulus: write 16 letters, then hold wr_valid_in;
  - response: count_out=16, wr_ready_out=0, and the 17th letter is not stored.
REQ-042 The bench SHALL cover clear against write:
  - stimulus: clear_in and wr_valid_in in the same cycle with count 3;
  - response: count_out=0 and no letter is stored.
REQ-043 The bench SHALL cover deferred commit:
  - stimulus: commit mid-frame, then new base_x_in=200;
  - response: letter_out, x_out and y_out are unchanged until hcount=0/vcount=0; afterwards the new letters appear at x 200; commit_pending_out falls on the boundary edge; wr_ready_out=0 while pending.
REQ-044 The bench SHALL cover reset mid-operation:
  - stimulus: assert rst_in during a row hit with a commit pending;
  - response: all outputs are 0 on the next edge; commit_pending_out=0; wr_ready_out=1 after release; the row renders blank.
